// File: rtl/skullfet_cell_exerciser.sv
// On-chip stimulus/checker for the SkullFET inverter and NAND cells.
// Optional SKULLFET_LFSR_EN selects LFSR stimulus; default build is exhaustive (v[2:0]).
module skullfet_cell_exerciser #(
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned ERR_W    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         num_vectors,
    input  logic [SETTLE_W-1:0] settle_cycles,
    output logic                inv_a,
    output logic                nand_a,
    output logic                nand_b,
    input  logic                inv_y,
    input  logic                nand_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [15:0]         vec_count,
    output logic [15:0]         first_fail_vec
);

    localparam int unsigned VEC_W = 16;
    localparam int unsigned CNT_W = SETTLE_W + 1;
    localparam logic [VEC_W-1:0] NO_FAIL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    n_q, n_d;
    logic [SETTLE_W-1:0] s_q, s_d;
    logic [VEC_W-1:0]    v_q, v_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [VEC_W-1:0]    ffv_q, ffv_d;
    logic [1:0]          sync1_q, sync2_q;
    logic                mismatch_c;

`ifdef SKULLFET_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d;
`endif

    // Cell outputs are asynchronous to wb_clk_i: bit 0 = inverter, bit 1 = NAND.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {nand_y, inv_y};
            sync2_q <= sync1_q;
        end
    end

    assign mismatch_c = (sync2_q[0] != ~stim_q[0]) ||
                        (sync2_q[1] != ~(stim_q[1] & stim_q[2]));

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        s_d     = s_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        vec_d   = vec_q;
        ffv_d   = ffv_q;
`ifdef SKULLFET_LFSR_EN
        lfsr_d  = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d   = num_vectors;
                    s_d   = settle_cycles;
                    err_d = '0;
                    vec_d = '0;
                    ffv_d = NO_FAIL;
                    v_d   = '0;
`ifdef SKULLFET_LFSR_EN
                    lfsr_d = LFSR_SEED;
`endif
                    state_d = (num_vectors == '0) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
`ifdef SKULLFET_LFSR_EN
                stim_d = lfsr_q[2:0];
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
                stim_d = v_q[2:0];
`endif
                // S+2 cycles in SETTLE: count S+1 down to 0.
                cnt_d   = CNT_W'(s_q) + CNT_W'(1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (ffv_q == NO_FAIL) begin
                        ffv_d = v_q;
                    end
                end
                vec_d   = v_q + VEC_W'(1);
                v_d     = v_q + VEC_W'(1);
                state_d = ((v_q + VEC_W'(1)) == n_q) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort cancels without a done pulse; partial counters are kept.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            pass_d  = pass_q;
        end

        if (state_d == ST_IDLE) begin
            stim_d = 3'b000;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            s_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            stim_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
            ffv_q   <= NO_FAIL;
`ifdef SKULLFET_LFSR_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            s_q     <= s_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            ffv_q   <= ffv_d;
`ifdef SKULLFET_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign inv_a          = stim_q[0];
    assign nand_a         = stim_q[1];
    assign nand_b         = stim_q[2];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign vec_count      = vec_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_skullfet_cell_exerciser.sv
// Scoreboard bench for skullfet_cell_exerciser with a switchable cell model.
module tb_skullfet_cell_exerciser;

    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned ERR_W    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [15:0]         nv = '0;
    logic [SETTLE_W-1:0] sc = '0;
    logic                inv_a, nand_a, nand_b, inv_y, nand_y;
    logic                busy, done, pass;
    logic [ERR_W-1:0]    err_count;
    logic [15:0]         vec_count, first_fail_vec;

    skullfet_cell_exerciser #(.SETTLE_W(SETTLE_W), .ERR_W(ERR_W)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start         (start),
        .abort         (abort),
        .num_vectors   (nv),
        .settle_cycles (sc),
        .inv_a         (inv_a),
        .nand_a        (nand_a),
        .nand_b        (nand_b),
        .inv_y         (inv_y),
        .nand_y        (nand_y),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .vec_count     (vec_count),
        .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cell model: 0 ideal, 1 inv_y stuck 0, 2 nand_y stuck 1, 3 ideal delayed 3 clocks.
    int mode = 0;
    logic [2:0] dly_inv = 3'b111;
    logic [2:0] dly_nand = 3'b111;
    always @(posedge clk) begin
        dly_inv  <= {dly_inv[1:0], ~inv_a};
        dly_nand <= {dly_nand[1:0], ~(nand_a & nand_b)};
    end
    assign inv_y  = (mode == 3) ? dly_inv[2]  : (mode == 1) ? 1'b0 : ~inv_a;
    assign nand_y = (mode == 3) ? dly_nand[2] : (mode == 2) ? 1'b1 : ~(nand_a & nand_b);

    typedef struct {
        int e0;
        int lat;
        int pass;
        int err;
        int vec;
        int ffv;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("done_latency", cyc - cur.e0, cur.lat);
                check("pass", pass, cur.pass);
                check("err_count", err_count, cur.err);
                check("vec_count", vec_count, cur.vec);
                check("first_fail_vec", first_fail_vec, cur.ffv);
            end
        end
    end

    task automatic kick(input int n, input int s);
        @(negedge clk);
        nv    = 16'(n);
        sc    = SETTLE_W'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_run(input int n, input int s, input int lat, input int p,
                             input int e, input int v, input int f);
        exp_t x;
        x.e0 = cyc + 2;
        x.lat = lat;
        x.pass = p;
        x.err = e;
        x.vec = v;
        x.ffv = f;
        sb.push_back(x);
        kick(n, s);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: got no done expected one within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_vec", vec_count, 0);
        check("rst_ffv", first_fail_vec, 16'hFFFF);
        check("rst_stim", {nand_b, nand_a, inv_a}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Ideal cells, N=8 S=2, with an ignored start mid-run.
        mode = 0;
        start_run(8, 2, 49, 1, 0, 8, 16'hFFFF);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        check("hold_pass", pass, 1);
        check("hold_vec", vec_count, 8);
        check("idle_stim", {nand_b, nand_a, inv_a}, 0);

        // N=0 completes straight away.
        start_run(0, 0, 1, 1, 0, 0, 16'hFFFF);
        check("n0_busy", busy, 1);
        wait_done(10);

        // inv_y stuck at 0.
        mode = 1;
        repeat (5) @(negedge clk);
        start_run(8, 0, 33, 0, 4, 8, 0);
        wait_done(100);

        // nand_y stuck at 1, 16 raw failures saturate a 4-bit counter.
        mode = 2;
        repeat (5) @(negedge clk);
        start_run(64, 0, 257, 0, 15, 64, 6);
        wait_done(400);

        // Slow cells: S=0 sees the previous vector's outputs, S=3 is enough.
        mode = 3;
        repeat (5) @(negedge clk);
        start_run(8, 0, 33, 0, 7, 8, 1);
        wait_done(100);
        repeat (5) @(negedge clk);
        start_run(8, 3, 57, 1, 0, 8, 16'hFFFF);
        wait_done(100);

        // Abort during vector 1.
        repeat (5) @(negedge clk);
        kick(8, 3);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_stim", {nand_b, nand_a, inv_a}, 0);
        check("abort_pass", pass, 1);
        check("abort_vec", vec_count, 1);
        check("abort_err", err_count, 0);
        repeat (40) @(negedge clk);

        // Reset during SETTLE of vector 3.
        mode = 0;
        repeat (5) @(negedge clk);
        kick(8, 2);
        repeat (20) @(negedge clk);
        check("pre_rst_stim", {nand_b, nand_a, inv_a}, 3);
        check("pre_rst_vec", vec_count, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stim", {nand_b, nand_a, inv_a}, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_vec", vec_count, 0);
        check("mid_rst_ffv", first_fail_vec, 16'hFFFF);
        check("mid_rst_pass", pass, 0);
        repeat (60) @(negedge clk);
        check("mid_rst_busy_later", busy, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
